// File: rtl/range_scan_ctrl.sv
// Range-insertion sequencer: walks every odometer combination of range chars over a template word.
// Optional collision/out-of-word check in SETUP is enabled by defining RANGE_SCAN_COLLISION_CHECK_EN.

module range_insert #(
    parameter int CHAR_BITS    = 7,
    parameter int WORD_MAX_LEN = 8,
    parameter int RANGES_MAX   = 4,
    parameter int SEL_BITS     = 2
) (
    input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] tmpl,
    input  logic [RANGES_MAX*CHAR_BITS-1:0]   digits,
    input  logic [WORD_MAX_LEN-1:0]           if_range,
    input  logic [WORD_MAX_LEN*SEL_BITS-1:0]  range_shift_val,
    output logic [WORD_MAX_LEN*CHAR_BITS-1:0] word
);

    // Each flagged position takes the digit of the range it was decoded to.
    always_comb begin
        word = tmpl;
        for (int i = 0; i < WORD_MAX_LEN; i++) begin
            for (int j = 0; j < RANGES_MAX; j++) begin
                if (if_range[i] && (range_shift_val[i*SEL_BITS +: SEL_BITS] == SEL_BITS'(j))) begin
                    word[i*CHAR_BITS +: CHAR_BITS] = digits[j*CHAR_BITS +: CHAR_BITS];
                end
            end
        end
    end

endmodule

module range_scan_ctrl #(
    parameter int CHAR_BITS      = 7,
    parameter int WORD_MAX_LEN   = 8,
    parameter int RANGES_MAX     = 4,
    parameter int RANGE_INFO_MSB = $clog2(WORD_MAX_LEN),
    parameter int CNT_BITS       = 16
) (
    input  logic                                     CLK,
    input  logic                                     reset_n,
    input  logic [WORD_MAX_LEN*CHAR_BITS-1:0]        tmpl_word,
    input  logic [RANGES_MAX*CHAR_BITS-1:0]          range_first,
    input  logic [RANGES_MAX*CHAR_BITS-1:0]          range_last,
    input  logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0] range_info,
    input  logic                                     tmpl_valid,
    output logic                                     tmpl_ready,
    output logic [WORD_MAX_LEN*CHAR_BITS-1:0]        dout,
    output logic                                     dout_valid,
    input  logic                                     dout_ready,
    output logic                                     dout_last,
    output logic [CNT_BITS-1:0]                      dout_cnt,
    output logic                                     err
);

    localparam int WORD_W   = WORD_MAX_LEN * CHAR_BITS;
    localparam int RNG_W    = RANGES_MAX * CHAR_BITS;
    localparam int INFO_W   = RANGE_INFO_MSB + 1;
    localparam int SEL_BITS = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    state_t                         state;
    logic [WORD_W-1:0]              tmpl_q;
    logic [RNG_W-1:0]               first_q;
    logic [RNG_W-1:0]               last_q;
    logic [RANGES_MAX*INFO_W-1:0]   info_q;
    logic [RNG_W-1:0]               digit_q;
    logic [WORD_MAX_LEN-1:0]        if_range_q;
    logic [WORD_MAX_LEN*SEL_BITS-1:0] range_shift_val_q;

    logic [RANGES_MAX-1:0]          act;
    logic [RNG_W-1:0]               eff_last;
    logic [RNG_W-1:0]               next_digits;
    logic [WORD_MAX_LEN-1:0]        dec_if_range;
    logic [WORD_MAX_LEN*SEL_BITS-1:0] dec_shift_val;
    logic [RNG_W-1:0]               ins_digits;
    logic [WORD_MAX_LEN-1:0]        ins_if_range;
    logic [WORD_MAX_LEN*SEL_BITS-1:0] ins_shift_val;
    logic [WORD_W-1:0]              ins_word;
    logic                           ins_last;
    logic                           collide;

    function automatic logic at_last(input logic [RNG_W-1:0]      d,
                                     input logic [RANGES_MAX-1:0] a,
                                     input logic [RNG_W-1:0]      el);
        logic r;
        r = 1'b1;
        for (int j = 0; j < RANGES_MAX; j++) begin
            if (a[j] && (d[j*CHAR_BITS +: CHAR_BITS] != el[j*CHAR_BITS +: CHAR_BITS])) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    // A range with last below first collapses to the single value first.
    always_comb begin
        act      = '0;
        eff_last = '0;
        for (int j = 0; j < RANGES_MAX; j++) begin
            act[j] = info_q[j*INFO_W + RANGE_INFO_MSB];
            if (last_q[j*CHAR_BITS +: CHAR_BITS] < first_q[j*CHAR_BITS +: CHAR_BITS]) begin
                eff_last[j*CHAR_BITS +: CHAR_BITS] = first_q[j*CHAR_BITS +: CHAR_BITS];
            end else begin
                eff_last[j*CHAR_BITS +: CHAR_BITS] = last_q[j*CHAR_BITS +: CHAR_BITS];
            end
        end
    end

    always_comb begin
        dec_if_range  = '0;
        dec_shift_val = '0;
        for (int i = 0; i < WORD_MAX_LEN; i++) begin
            for (int j = 0; j < RANGES_MAX; j++) begin
                if (act[j] && (int'(info_q[j*INFO_W +: RANGE_INFO_MSB]) + j == i)) begin
                    dec_if_range[i] = 1'b1;
                    dec_shift_val[i*SEL_BITS +: SEL_BITS] = SEL_BITS'(j);
                end
            end
        end
    end

`ifdef RANGE_SCAN_COLLISION_CHECK_EN
    always_comb begin
        logic [WORD_MAX_LEN-1:0] seen;
        seen    = '0;
        collide = 1'b0;
        for (int j = 0; j < RANGES_MAX; j++) begin
            if (act[j]) begin
                if (int'(info_q[j*INFO_W +: RANGE_INFO_MSB]) + j >= WORD_MAX_LEN) begin
                    collide = 1'b1;
                end
                for (int i = 0; i < WORD_MAX_LEN; i++) begin
                    if (int'(info_q[j*INFO_W +: RANGE_INFO_MSB]) + j == i) begin
                        if (seen[i]) begin
                            collide = 1'b1;
                        end
                        seen[i] = 1'b1;
                    end
                end
            end
        end
    end
`else
    assign collide = 1'b0;
    assign err     = 1'b0;
`endif

    // Odometer: digit 0 moves fastest, inactive digits pass the carry through.
    always_comb begin
        logic carry;
        carry       = 1'b1;
        next_digits = digit_q;
        for (int j = 0; j < RANGES_MAX; j++) begin
            if (act[j] && carry) begin
                if (digit_q[j*CHAR_BITS +: CHAR_BITS] == eff_last[j*CHAR_BITS +: CHAR_BITS]) begin
                    next_digits[j*CHAR_BITS +: CHAR_BITS] = first_q[j*CHAR_BITS +: CHAR_BITS];
                end else begin
                    next_digits[j*CHAR_BITS +: CHAR_BITS] =
                        digit_q[j*CHAR_BITS +: CHAR_BITS] + CHAR_BITS'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    // SETUP builds the first word from freshly decoded controls; RUN uses the registered ones.
    always_comb begin
        ins_digits    = next_digits;
        ins_if_range  = if_range_q;
        ins_shift_val = range_shift_val_q;
        if (state == SETUP) begin
            ins_digits    = first_q;
            ins_if_range  = dec_if_range;
            ins_shift_val = dec_shift_val;
        end
        ins_last = at_last(ins_digits, act, eff_last);
    end

    range_insert #(
        .CHAR_BITS    (CHAR_BITS),
        .WORD_MAX_LEN (WORD_MAX_LEN),
        .RANGES_MAX   (RANGES_MAX),
        .SEL_BITS     (SEL_BITS)
    ) u_insert (
        .tmpl            (tmpl_q),
        .digits          (ins_digits),
        .if_range        (ins_if_range),
        .range_shift_val (ins_shift_val),
        .word            (ins_word)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            tmpl_q            <= '0;
            first_q           <= '0;
            last_q            <= '0;
            info_q            <= '0;
            digit_q           <= '0;
            if_range_q        <= '0;
            range_shift_val_q <= '0;
            tmpl_ready        <= 1'b1;
            dout_valid        <= 1'b0;
            dout_last         <= 1'b0;
            dout_cnt          <= '0;
            dout              <= '0;
`ifdef RANGE_SCAN_COLLISION_CHECK_EN
            err               <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tmpl_ready <= 1'b1;
                    dout_valid <= 1'b0;
                    if (tmpl_valid) begin
                        tmpl_q     <= tmpl_word;
                        first_q    <= range_first;
                        last_q     <= range_last;
                        info_q     <= range_info;
                        tmpl_ready <= 1'b0;
                        state      <= SETUP;
`ifdef RANGE_SCAN_COLLISION_CHECK_EN
                        err        <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    if_range_q        <= dec_if_range;
                    range_shift_val_q <= dec_shift_val;
                    digit_q           <= first_q;
                    dout_cnt          <= '0;
                    if (collide) begin
                        state      <= IDLE;
                        tmpl_ready <= 1'b1;
`ifdef RANGE_SCAN_COLLISION_CHECK_EN
                        err        <= 1'b1;
`endif
                    end else begin
                        state      <= RUN;
                        dout_valid <= 1'b1;
                        dout       <= ins_word;
                        dout_last  <= ins_last;
                    end
                end
                RUN: begin
                    if (dout_ready) begin
                        dout_cnt <= dout_cnt + CNT_BITS'(1);
                        if (dout_last) begin
                            state      <= IDLE;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            tmpl_ready <= 1'b1;
                        end else begin
                            digit_q   <= next_digits;
                            dout      <= ins_word;
                            dout_last <= ins_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Directed self-checking bench for range_scan_ctrl; the collision test runs when
// RANGE_SCAN_COLLISION_CHECK_EN is defined.

module tb_range_scan_ctrl;

    logic        CLK;
    logic        reset_n;
    logic [55:0] tmpl_word;
    logic [27:0] range_first;
    logic [27:0] range_last;
    logic [15:0] range_info;
    logic        tmpl_valid;
    logic        tmpl_ready;
    logic [55:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic [15:0] dout_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    range_scan_ctrl dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .tmpl_word   (tmpl_word),
        .range_first (range_first),
        .range_last  (range_last),
        .range_info  (range_info),
        .tmpl_valid  (tmpl_valid),
        .tmpl_ready  (tmpl_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .dout_cnt    (dout_cnt),
        .err         (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [55:0] mk_word(input string s);
        logic [55:0] w;
        byte         b;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            b = s[i];
            w[i*7 +: 7] = b[6:0];
        end
        return w;
    endfunction

    function automatic logic [27:0] pack_ch(input byte c0, input byte c1, input byte c2, input byte c3);
        return {c3[6:0], c2[6:0], c1[6:0], c0[6:0]};
    endfunction

    function automatic logic [3:0] ri(input logic a, input logic [2:0] s);
        return {a, s};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one template for a single accepting edge; call only while idle.
    task automatic applyStimulus(input logic [55:0] tw, input logic [27:0] rf,
                                 input logic [27:0] rl, input logic [15:0] info);
        tmpl_word   = tw;
        range_first = rf;
        range_last  = rl;
        range_info  = info;
        tmpl_valid  = 1'b1;
        tick();
        tmpl_valid  = 1'b0;
    endtask

    logic [55:0] exp_w [4];
    logic [31:0] pat;
    int          idx;
    int          cyc;

    initial begin
        reset_n     = 1'b0;
        tmpl_word   = '0;
        range_first = '0;
        range_last  = '0;
        range_info  = '0;
        tmpl_valid  = 1'b0;
        dout_ready  = 1'b1;
        tick();
        tick();
        checkOutput("rst_tmpl_ready", tmpl_ready, 1);
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_dout_last", dout_last, 0);
        checkOutput("rst_dout_cnt", dout_cnt, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_err", err, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] single range at shift 4");
        applyStimulus(mk_word("pass----"), pack_ch("a", "0", "0", "0"),
                      pack_ch("c", "0", "0", "0"),
                      {ri(0, 0), ri(0, 0), ri(0, 0), ri(1, 4)});
        checkOutput("t1_setup_valid", dout_valid, 0);
        checkOutput("t1_setup_ready", tmpl_ready, 0);
        tick();
        checkOutput("t1_w0", dout, mk_word("passa---"));
        checkOutput("t1_v0", dout_valid, 1);
        checkOutput("t1_c0", dout_cnt, 0);
        checkOutput("t1_l0", dout_last, 0);
        tick();
        checkOutput("t1_w1", dout, mk_word("passb---"));
        checkOutput("t1_c1", dout_cnt, 1);
        checkOutput("t1_l1", dout_last, 0);
        tick();
        checkOutput("t1_w2", dout, mk_word("passc---"));
        checkOutput("t1_c2", dout_cnt, 2);
        checkOutput("t1_l2", dout_last, 1);
        tick();
        checkOutput("t1_end_valid", dout_valid, 0);
        checkOutput("t1_end_ready", tmpl_ready, 1);

        $display("[TB] two ranges, odometer order");
        exp_w[0] = mk_word("0x------");
        exp_w[1] = mk_word("1x------");
        exp_w[2] = mk_word("0y------");
        exp_w[3] = mk_word("1y------");
        applyStimulus(mk_word("--------"), pack_ch("0", "x", "0", "0"),
                      pack_ch("1", "y", "0", "0"),
                      {ri(0, 0), ri(0, 0), ri(1, 0), ri(1, 0)});
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("t2_w%0d", k), dout, exp_w[k]);
            checkOutput($sformatf("t2_c%0d", k), dout_cnt, 64'(k));
            checkOutput($sformatf("t2_l%0d", k), dout_last, (k == 3) ? 1 : 0);
        end
        tick();
        checkOutput("t2_end_valid", dout_valid, 0);

        $display("[TB] no active ranges");
        applyStimulus(mk_word("hello!!!"), '0, '0, '0);
        tick();
        checkOutput("t3_w", dout, mk_word("hello!!!"));
        checkOutput("t3_v", dout_valid, 1);
        checkOutput("t3_l", dout_last, 1);
        checkOutput("t3_c", dout_cnt, 0);
        tick();
        checkOutput("t3_ready_back", tmpl_ready, 1);
        checkOutput("t3_valid_off", dout_valid, 0);

        $display("[TB] two ranges with stalls");
        pat = 32'b1101_0110_0101_1011_0010_1001_1100_0110;
        applyStimulus(mk_word("--------"), pack_ch("0", "x", "0", "0"),
                      pack_ch("1", "y", "0", "0"),
                      {ri(0, 0), ri(0, 0), ri(1, 0), ri(1, 0)});
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 32) begin
            dout_ready = pat[cyc];
            if (dout_valid) begin
                checkOutput($sformatf("t4_w%0d_cyc%0d", idx, cyc), dout, exp_w[idx]);
                checkOutput($sformatf("t4_c%0d_cyc%0d", idx, cyc), dout_cnt, 64'(idx));
                checkOutput($sformatf("t4_l%0d_cyc%0d", idx, cyc), dout_last, (idx == 3) ? 1 : 0);
                if (dout_ready) idx++;
            end
            tick();
            cyc++;
        end
        checkOutput("t4_word_count", 64'(idx), 4);
        dout_ready = 1'b1;
        checkOutput("t4_end_valid", dout_valid, 0);
        checkOutput("t4_end_ready", tmpl_ready, 1);

        $display("[TB] reset in mid template");
        applyStimulus(mk_word("--------"), pack_ch("0", "x", "0", "0"),
                      pack_ch("1", "y", "0", "0"),
                      {ri(0, 0), ri(0, 0), ri(1, 0), ri(1, 0)});
        tick();
        tick();
        tick();
        checkOutput("t5_pre_w", dout, exp_w[2]);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", dout_valid, 0);
        checkOutput("t5_rst_ready", tmpl_ready, 1);
        checkOutput("t5_rst_cnt", dout_cnt, 0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("t5_quiet%0d", k), dout_valid, 0);
        end
        applyStimulus(mk_word("pass----"), pack_ch("a", "0", "0", "0"),
                      pack_ch("c", "0", "0", "0"),
                      {ri(0, 0), ri(0, 0), ri(0, 0), ri(1, 4)});
        tick();
        checkOutput("t5_new_w0", dout, mk_word("passa---"));
        checkOutput("t5_new_c0", dout_cnt, 0);
        tick();
        tick();
        tick();
        checkOutput("t5_new_end", dout_valid, 0);

        $display("[TB] single-valued range (last below first)");
        applyStimulus(mk_word("--------"), pack_ch("q", "0", "0", "0"),
                      pack_ch("c", "2", "0", "0"),
                      {ri(0, 0), ri(0, 0), ri(1, 2), ri(1, 2)});
        tick();
        checkOutput("t6_w0", dout, mk_word("--q0----"));
        tick();
        checkOutput("t6_w1", dout, mk_word("--q1----"));
        checkOutput("t6_l1", dout_last, 0);
        tick();
        checkOutput("t6_w2", dout, mk_word("--q2----"));
        checkOutput("t6_l2", dout_last, 1);
        checkOutput("t6_err", err, 0);
        tick();
        checkOutput("t6_end", dout_valid, 0);

`ifdef RANGE_SCAN_COLLISION_CHECK_EN
        $display("[TB] collision detection");
        applyStimulus(mk_word("--------"), pack_ch("a", "b", "0", "0"),
                      pack_ch("c", "d", "0", "0"),
                      {ri(0, 0), ri(0, 0), ri(1, 0), ri(1, 1)});
        tick();
        checkOutput("t7_valid", dout_valid, 0);
        checkOutput("t7_err", err, 1);
        checkOutput("t7_ready", tmpl_ready, 1);
        tick();
        tick();
        checkOutput("t7_err_hold", err, 1);
        checkOutput("t7_valid_hold", dout_valid, 0);
        applyStimulus(mk_word("hello!!!"), '0, '0, '0);
        checkOutput("t7_err_clear", err, 0);
        tick();
        checkOutput("t7_next_w", dout, mk_word("hello!!!"));
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/range_scan_ctrl.md
# range_scan_ctrl

Sequencer for the range-insertion datapath in the candidate-word generator. It accepts one template word plus per-range character bounds and range placement info, then walks every combination of range characters in odometer order. Each combination is emitted as a finished word over a valid/ready stream toward the hash-core input FIFO. It owns the `range_insert` instance and precomputes its per-position select and shift controls.

## Interface
- `CHAR_BITS`, 7, bits per character.
- `WORD_MAX_LEN`, 8, characters per word.
- `RANGES_MAX`, 4, number of range slots.
- `RANGE_INFO_MSB`, 1 + `MSB(WORD_MAX_LEN-1)`, shift-field width; each `range_info` entry is `RANGE_INFO_MSB+1` bits.
- `CNT_BITS`, 16, width of the per-template word counter.

Ports:
- `CLK` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tmpl_word` in `WORD_MAX_LEN*CHAR_BITS`: template word, char 0 in the LSBs.
- `range_first` in `RANGES_MAX*CHAR_BITS`: first char of each range.
- `range_last` in `RANGES_MAX*CHAR_BITS`: last char of each range, inclusive.
- `range_info` in `RANGES_MAX*(RANGE_INFO_MSB+1)`: per-range entry; MSB = active, low bits = shift. Range j lands at position shift+j.
- `tmpl_valid` in 1 / `tmpl_ready` out 1: template handshake.
- `dout` out `WORD_MAX_LEN*CHAR_BITS`: generated word.
- `dout_valid` in/out: out 1. `dout_ready` in 1: output handshake.
- `dout_last` out 1: marks the final word of the template.
- `dout_cnt` out `CNT_BITS`: index of the current word within its template.
- `err` out 1: collision error, present only with the macro in Configuration.

## Operation
- FSM states: IDLE, SETUP, RUN.
- IDLE: `tmpl_ready`=1. When `tmpl_valid` is high, register all template inputs and go to SETUP.
- SETUP, one cycle:
  - Decode range_info into per-position `if_range[i]` and `range_shift_val[i]`, and register them.
  - Load odometer digit j = `range_first[j]`; clear `dout_cnt`; go to RUN.
- RUN: `dout_valid`=1. `dout` = `range_insert`(template, odometer digits, registered controls).
  - `dout` is driven only from registers; there is no combinational path from any input.
- Odometer step, on each `dout_valid&dout_ready`:
  - Digit 0 is the fastest-moving digit.
  - An active digit at its `last` value wraps to `first` and carries to the next digit; otherwise it increments by 1 and the carry stops.
  - Inactive digits pass the carry through unchanged.
  - `dout_cnt` increments and wraps modulo 2^CNT_BITS.
- `last < first`: that range is single-valued; it holds `first` and always carries.
- `dout_last`=1 when every active digit equals its effective last value. The handshake on that word returns the FSM to IDLE.
- Zero active ranges: exactly one word is emitted, equal to `tmpl_word`, with `dout_last`=1.
- Words per template = product over active ranges of (last-first+1).

## Timing
- Reset values: state=IDLE, `tmpl_ready`=1, `dout_valid`=0, `dout_last`=0, `dout_cnt`=0, `dout`=0, `err`=0.
- An accept on edge T gives SETUP during T+1 and first word valid from T+2. Latency is 2 cycles.
- Throughput is one word per cycle while `dout_ready`=1.
- With `dout_ready`=0, `dout`, `dout_last` and `dout_cnt` hold stable.
- `tmpl_ready`=0 in SETUP and RUN. `tmpl_ready` returns to 1 on the cycle after the last handshake, so there is one bubble between templates.
- `reset_n` low at any point clears all state asynchronously. The partially emitted template is dropped and no word is emitted after deassertion until a new template is accepted.

## Configuration
- `RANGE_SCAN_COLLISION_CHECK_EN`, if defined:
  - SETUP checks for two active ranges targeting the same position, or shift+j ≥ WORD_MAX_LEN.
  - On a hit, the FSM goes SETUP→IDLE with no words emitted and `err`=1.
  - `err` holds until the next template accept.
- If not defined:
  - No check is made and `err` is tied to 0.
  - A colliding position carries an undefined char.
  - Out-of-word ranges are silently dropped.

## Test plan
- Template "pass----", range0 first='a' last='c' shift 4 active, others inactive, `dout_ready`=1 → 3 words "passa---", "passb---", "passc---"; `dout_cnt` 0,1,2; `dout_last` only on the third; first word 2 cycles after accept.
- Ranges 0 ('0'–'1', shift 0) and 1 ('x'–'y', shift 0 → position 1) → order "0x", "1x", "0y", "1y"; 4 words.
- All ranges inactive → single word equal to template with `dout_last`=1; `tmpl_ready` high again the next cycle.
- Random `dout_ready` toggling on the 2×2 case → the same 4 words with no duplicates or drops; outputs stable while stalled.
- `reset_n` pulsed low after the 2nd of 4 words → `dout_valid`=0 immediately, `tmpl_ready`=1; a new template restarts at `dout_cnt`=0.
- With `RANGE_SCAN_COLLISION_CHECK_EN`, range0 shift 1 and range1 shift 0 (both at position 1) → no `dout_valid`, `err`=1 until the next accept.
